// File: rtl/at_row_alloc.sv
// Allocation-tree row responder: buddy allocation and release on per-row 8-slot
// bitmaps, returning the allocated offset and the row's refreshed availability vector.
module at_row_alloc #(
    parameter int ID_W  = 4,
    parameter int ROW_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid_in,
    input  logic [ID_W-1:0]  alloc_id_in,
    input  logic [ROW_W-1:0] alloc_row_in,
    input  logic [1:0]       alloc_size_in,
    input  logic             free_valid_in,
    output logic             free_ready_out,
    input  logic [ROW_W-1:0] free_row_in,
    input  logic [2:0]       free_offset_in,
    input  logic [1:0]       free_size_in,
    output logic             alloc_rsp_valid_out,
    output logic [ID_W-1:0]  alloc_rsp_id_out,
    output logic [ROW_W-1:0] alloc_rsp_row_out,
    output logic [2:0]       alloc_rsp_offset_out,
    output logic             alloc_rsp_fail_out,
    output logic             free_err_out,
    output logic             fdt_update_valid_out,
    output logic [ROW_W-1:0] fdt_update_idx_out,
    output logic [3:0]       fdt_update_bit_sequence_out
);
    localparam int ROWS = 2 ** ROW_W;

    // Handshake: alloc has no backpressure and is taken whenever alloc_valid_in is
    // high; a free transfers only in a cycle where free_valid_in && free_ready_out.
    assign free_ready_out = !alloc_valid_in && !rst;

    logic [7:0]       mem [ROWS];
    logic             s0_valid;
    logic             s0_alloc;
    logic [ID_W-1:0]  s0_id;
    logic [ROW_W-1:0] s0_row;
    logic [1:0]       s0_size;
    logic [2:0]       s0_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid  <= 1'b0;
            s0_alloc  <= 1'b0;
            s0_id     <= '0;
            s0_row    <= '0;
            s0_size   <= '0;
            s0_offset <= '0;
        end else begin
            s0_valid <= alloc_valid_in || free_valid_in;
            s0_alloc <= alloc_valid_in;
            if (alloc_valid_in) begin
                s0_id     <= alloc_id_in;
                s0_row    <= alloc_row_in;
                s0_size   <= alloc_size_in;
                s0_offset <= '0;
            end else if (free_valid_in) begin
                s0_id     <= '0;
                s0_row    <= free_row_in;
                s0_size   <= free_size_in;
                s0_offset <= free_offset_in;
            end
        end
    end

    logic [7:0] cur;
    logic [7:0] base;
    logic [7:0] next_bm;
    logic [2:0] align;
    logic [2:0] pick;
    logic       found;
    logic       err;
    logic [3:0] seq;

    always_comb begin
        cur   = mem[s0_row];
        base  = 8'hFF;
        align = 3'd7;
        case (s0_size)
            2'd0: begin base = 8'h01; align = 3'd0; end
            2'd1: begin base = 8'h03; align = 3'd1; end
            2'd2: begin base = 8'h0F; align = 3'd3; end
            default: begin base = 8'hFF; align = 3'd7; end
        endcase
        // Descending scan so the lowest fitting aligned candidate is the last one kept.
        found = 1'b0;
        pick  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (((3'(i) & align) == 3'd0) && ((cur & (base << 3'(i))) == 8'h00)) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        // Shifting within 8 bits clips a misaligned free at slot 7.
        err = ((cur & (base << s0_offset)) != (base << s0_offset)) ||
              ((s0_offset & align) != 3'd0);
        if (s0_alloc) begin
            next_bm = found ? (cur | (base << pick)) : cur;
        end else begin
            next_bm = cur & ~(base << s0_offset);
        end
        seq[0] = &next_bm;
        seq[1] = (|next_bm[1:0]) && (|next_bm[3:2]) && (|next_bm[5:4]) && (|next_bm[7:6]);
        seq[2] = (|next_bm[3:0]) && (|next_bm[7:4]);
        seq[3] = |next_bm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[r] <= '0;
            end
            alloc_rsp_valid_out         <= 1'b0;
            alloc_rsp_id_out            <= '0;
            alloc_rsp_row_out           <= '0;
            alloc_rsp_offset_out        <= '0;
            alloc_rsp_fail_out          <= 1'b0;
            free_err_out                <= 1'b0;
            fdt_update_valid_out        <= 1'b0;
            fdt_update_idx_out          <= '0;
            fdt_update_bit_sequence_out <= '0;
        end else begin
            alloc_rsp_valid_out  <= s0_valid && s0_alloc;
            fdt_update_valid_out <= s0_valid;
            free_err_out         <= s0_valid && !s0_alloc && err;
            if (s0_valid) begin
                mem[s0_row]                 <= next_bm;
                fdt_update_idx_out          <= s0_row;
                fdt_update_bit_sequence_out <= seq;
                if (s0_alloc) begin
                    alloc_rsp_id_out     <= s0_id;
                    alloc_rsp_row_out    <= s0_row;
                    alloc_rsp_offset_out <= found ? pick : 3'd0;
                    alloc_rsp_fail_out   <= !found;
                end
            end
        end
    end
endmodule

// File: tb/tb_at_row_alloc.sv
// Bench for at_row_alloc: directed scenarios plus randomized traffic checked
// against a bitmap reference model with a two-cycle expectation pipeline.
module tb_at_row_alloc;
    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid_in;
    logic [3:0] alloc_id_in;
    logic [5:0] alloc_row_in;
    logic [1:0] alloc_size_in;
    logic       free_valid_in;
    logic       free_ready_out;
    logic [5:0] free_row_in;
    logic [2:0] free_offset_in;
    logic [1:0] free_size_in;
    logic       alloc_rsp_valid_out;
    logic [3:0] alloc_rsp_id_out;
    logic [5:0] alloc_rsp_row_out;
    logic [2:0] alloc_rsp_offset_out;
    logic       alloc_rsp_fail_out;
    logic       free_err_out;
    logic       fdt_update_valid_out;
    logic [5:0] fdt_update_idx_out;
    logic [3:0] fdt_update_bit_sequence_out;

    at_row_alloc #(.ID_W(4), .ROW_W(6)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid_in(alloc_valid_in), .alloc_id_in(alloc_id_in),
        .alloc_row_in(alloc_row_in), .alloc_size_in(alloc_size_in),
        .free_valid_in(free_valid_in), .free_ready_out(free_ready_out),
        .free_row_in(free_row_in), .free_offset_in(free_offset_in),
        .free_size_in(free_size_in),
        .alloc_rsp_valid_out(alloc_rsp_valid_out), .alloc_rsp_id_out(alloc_rsp_id_out),
        .alloc_rsp_row_out(alloc_rsp_row_out), .alloc_rsp_offset_out(alloc_rsp_offset_out),
        .alloc_rsp_fail_out(alloc_rsp_fail_out), .free_err_out(free_err_out),
        .fdt_update_valid_out(fdt_update_valid_out), .fdt_update_idx_out(fdt_update_idx_out),
        .fdt_update_bit_sequence_out(fdt_update_bit_sequence_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_alloc;
        bit         is_free;
        logic [3:0] id;
        logic [5:0] row;
        logic [2:0] off;
        logic       fail;
        logic       err;
        logic [3:0] seq;
        int         tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] bm [64];
    logic [2:0] obs_off  [int];
    logic       obs_fail [int];
    logic       obs_err  [int];
    logic [3:0] obs_seq  [int];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Bit k set when no aligned run of 2^k free slots exists anywhere in the row.
    function automatic logic [3:0] model_seq(input logic [7:0] b);
        logic [3:0] s;
        for (int k = 0; k < 4; k++) begin
            int  g = 1 << k;
            bit  any_free = 0;
            for (int o = 0; o < 8; o += g) begin
                bit all_free = 1;
                for (int j = 0; j < g; j++) if (b[o + j]) all_free = 0;
                if (all_free) any_free = 1;
            end
            s[k] = !any_free;
        end
        return s;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.is_alloc = 0; e.is_free = 0; e.id = '0; e.row = '0; e.off = '0;
        e.fail = 0; e.err = 0; e.seq = '0; e.tag = -1;
        return e;
    endfunction

    task automatic check_exp(input exp_t c);
        chk("rsp_valid", alloc_rsp_valid_out, c.is_alloc);
        chk("upd_valid", fdt_update_valid_out, c.is_alloc | c.is_free);
        chk("free_err", free_err_out, c.err);
        if (c.is_alloc) begin
            chk("rsp_id", alloc_rsp_id_out, c.id);
            chk("rsp_row", alloc_rsp_row_out, c.row);
            chk("rsp_offset", alloc_rsp_offset_out, c.off);
            chk("rsp_fail", alloc_rsp_fail_out, c.fail);
        end
        if (c.is_alloc || c.is_free) begin
            chk("upd_idx", fdt_update_idx_out, c.row);
            chk("upd_seq", fdt_update_bit_sequence_out, c.seq);
        end
        if (c.tag >= 0) begin
            obs_off[c.tag]  = alloc_rsp_offset_out;
            obs_fail[c.tag] = alloc_rsp_fail_out;
            obs_err[c.tag]  = free_err_out;
            obs_seq[c.tag]  = fdt_update_bit_sequence_out;
        end
    endtask

    // One clock cycle: checks the op issued two cycles ago, drives this cycle's inputs.
    task automatic step(input bit av, input logic [3:0] aid, input logic [5:0] arow,
                        input logic [1:0] asz, input bit fv, input logic [5:0] frow,
                        input logic [2:0] foff, input logic [1:0] fsz, input int tag);
        exp_t e;
        if (exp_q.size() >= 2) check_exp(exp_q.pop_front());
        alloc_valid_in = av; alloc_id_in = aid; alloc_row_in = arow; alloc_size_in = asz;
        free_valid_in = fv; free_row_in = frow; free_offset_in = foff; free_size_in = fsz;
        e = idle_exp();
        e.tag = tag;
        if (av) begin
            int g = 1 << asz;
            e.is_alloc = 1; e.id = aid; e.row = arow; e.fail = 1; e.off = 0;
            for (int o = 0; o + g <= 8 && e.fail; o += g) begin
                bit fits = 1;
                for (int j = 0; j < g; j++) if (bm[arow][o + j]) fits = 0;
                if (fits) begin
                    e.fail = 0; e.off = 3'(o);
                    for (int j = 0; j < g; j++) bm[arow][o + j] = 1'b1;
                end
            end
            e.seq = model_seq(bm[arow]);
        end else if (fv) begin
            int g = 1 << fsz;
            e.is_free = 1; e.row = frow;
            e.err = (int'(foff) % g) != 0;
            for (int j = int'(foff); j < int'(foff) + g && j < 8; j++) begin
                if (!bm[frow][j]) e.err = 1;
                bm[frow][j] = 1'b0;
            end
            e.seq = model_seq(bm[frow]);
        end
        #1;
        chk("free_ready", free_ready_out, !av);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [3:0] id, input logic [5:0] row, input logic [1:0] sz,
                         input int tag);
        step(1, id, row, sz, 0, '0, '0, '0, tag);
    endtask

    task automatic free_op(input logic [5:0] row, input logic [2:0] off, input logic [1:0] sz,
                           input int tag);
        step(0, '0, '0, '0, 1, row, off, sz, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, '0, -1);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 64; r++) bm[r] = '0;
        exp_q.delete();
        exp_q.push_back(idle_exp());
        exp_q.push_back(idle_exp());
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid_in = 0; alloc_id_in = '0; alloc_row_in = '0; alloc_size_in = '0;
        free_valid_in = 0; free_row_in = '0; free_offset_in = '0; free_size_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", alloc_rsp_valid_out, 0);
        chk("reset_upd_valid", fdt_update_valid_out, 0);
        chk("reset_free_err", free_err_out, 0);
        chk("reset_upd_seq", fdt_update_bit_sequence_out, 0);
        chk("reset_free_ready", free_ready_out, 0);
        rst = 1'b0;
        model_reset();

        alloc(4'd3, 6'd5, 2'd0, 1);
        idle(2);
        chk("plan_first_off", obs_off[1], 0);
        chk("plan_first_fail", obs_fail[1], 0);
        chk("plan_first_seq", obs_seq[1], 4'b1000);

        alloc(4'd1, 6'd7, 2'd1, 10);
        alloc(4'd2, 6'd7, 2'd0, 11);
        alloc(4'd4, 6'd7, 2'd2, 12);
        alloc(4'd5, 6'd7, 2'd0, 13);
        idle(2);
        chk("plan_row7_off_a", obs_off[10], 0);
        chk("plan_row7_off_b", obs_off[11], 2);
        chk("plan_row7_off_c", obs_off[12], 4);
        chk("plan_row7_seq_c", obs_seq[12], 4'b1110);
        chk("plan_row7_off_d", obs_off[13], 3);
        chk("plan_row7_seq_d", obs_seq[13], 4'b1111);

        for (int i = 0; i < 8; i++) alloc(4'(i), 6'd2, 2'd0, 20 + i);
        alloc(4'd9, 6'd2, 2'd0, 28);
        idle(2);
        chk("plan_full_fail", obs_fail[28], 1);
        chk("plan_full_off", obs_off[28], 0);
        chk("plan_full_seq", obs_seq[28], 4'b1111);

        step(1, 4'd6, 6'd1, 2'd3, 1, 6'd0, 3'd0, 2'd0, 30);
        free_op(6'd0, 3'd0, 2'd0, 31);
        idle(2);
        chk("plan_conflict_free_err", obs_err[31], 1);

        alloc(4'd7, 6'd4, 2'd3, 40);
        free_op(6'd4, 3'd4, 2'd2, 41);
        free_op(6'd4, 3'd4, 2'd2, 42);
        alloc(4'd8, 6'd4, 2'd2, 43);
        idle(2);
        chk("plan_free_ok_err", obs_err[41], 0);
        chk("plan_free_ok_seq", obs_seq[41], 4'b1000);
        chk("plan_free_again_err", obs_err[42], 1);
        chk("plan_free_again_seq", obs_seq[42], 4'b1000);
        chk("plan_refill_off", obs_off[43], 4);

        alloc(4'd2, 6'd9, 2'd3, 50);
        free_op(6'd9, 3'd6, 2'd2, 51);
        idle(2);
        chk("plan_misaligned_err", obs_err[51], 1);
        chk("plan_misaligned_seq", obs_seq[51], 4'b1100);

        alloc(4'd11, 6'd12, 2'd3, 60);
        rst = 1'b1;
        alloc_valid_in = 0; free_valid_in = 0;
        @(posedge clk);
        #1;
        chk("inflight_rsp_dropped", alloc_rsp_valid_out, 0);
        chk("inflight_upd_dropped", fdt_update_valid_out, 0);
        chk("inflight_free_ready", free_ready_out, 0);
        rst = 1'b0;
        model_reset();
        alloc(4'd12, 6'd12, 2'd3, 61);
        alloc(4'd13, 6'd7, 2'd3, 62);
        idle(2);
        chk("plan_after_rst_off12", obs_off[61], 0);
        chk("plan_after_rst_fail12", obs_fail[61], 0);
        chk("plan_after_rst_off7", obs_off[62], 0);
        chk("plan_after_rst_fail7", obs_fail[62], 0);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 2) == 0, 4'($urandom), 6'($urandom_range(0, 3)),
                 2'($urandom), $urandom_range(0, 1) == 1, 6'($urandom_range(0, 3)),
                 3'($urandom), 2'($urandom), -1);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
